// File: rtl/program_loader.sv
// program_loader: 16x8 writable instruction store fed by a checksummed byte-stream loader.
// The CPU is held off the read port until a complete image with a matching checksum is present.
module program_loader #(
    parameter int ADRS_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADRS_W-1:0] cpu_adrs,
    output logic [DATA_W-1:0] cpu_inst,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADRS_W:0]   load_count
);
    localparam int DEPTH = 2**ADRS_W;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 2);
    localparam logic [ADRS_W:0]   CHK_IDX  = (ADRS_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

    state_t                       state;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DATA_W-1:0]            acc;
    logic [DATA_W-1:0]            chk;
    logic [TMO_W-1:0]             tmo_cnt;
    logic                         xfer;

    // All handshake/status outputs decode straight from the state register.
    assign in_ready  = (state == LOAD);
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);
    assign load_err  = (state == ERROR);
    assign xfer      = in_ready && in_valid;
    assign cpu_inst  = cpu_hold ? '0 : mem[cpu_adrs];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem        <= '0;
            acc        <= '0;
            chk        <= '0;
            tmo_cnt    <= '0;
            load_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_count <= '0;
                        acc        <= '0;
                        tmo_cnt    <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        tmo_cnt    <= '0;
                        load_count <= load_count + 1'b1;
                        // Beat after the last word carries the checksum, not an instruction.
                        if (load_count == CHK_IDX) begin
                            chk   <= in_data;
                            state <= CHECK;
                        end else begin
                            mem[load_count[ADRS_W-1:0]] <= in_data;
                            acc <= acc + in_data;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Aborts on the idle cycle that would bring the count to TIMEOUT-1.
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK:   state <= (acc == chk) ? DONE : ERROR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
